ped_crossing_controller: RTL and testbench

Cycle-timed controller for a single mid-block pedestrian crossing. Sequences the main-road traffic light and the pedestrian signal in response to a push-button request. Produces the one-hot 3-bit pedestrian state `{walk, flashing_dont_walk, dont_walk}` consumed directly by the downstream hex-display walk stage, plus the main-road red/yellow/green lamp drives.

---
 rtl/ped_crossing_controller.sv | 127 ++++++++++++
 tb/tb_ped_crossing_controller.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ped_crossing_controller.sv
// ped_crossing_controller: tick-timed main-road / pedestrian crossing sequencer.
// Optional PED_BUTTON_SYNC_EN adds a two-flop synchronizer on walk_button.
module ped_crossing_controller #(
  parameter int CLK_PER_TICK = 4,
  parameter int GREEN_MIN    = 6,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 2,
  parameter int WALK_T       = 5,
  parameter int FLASH_T      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       walk_button,
  output logic [2:0] ped_state,
  output logic [2:0] main_light,
  output logic       request_pending
);
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_PRE  = 3'd2,
    WALK        = 3'd3,
    FLASH       = 3'd4,
    ALLRED_POST = 3'd5
  } state_t;

  function automatic logic [7:0] reload(input state_t s);
    case (s)
      MAIN_GREEN:  return 8'(GREEN_MIN - 1);
      MAIN_YELLOW: return 8'(YELLOW_T - 1);
      WALK:        return 8'(WALK_T - 1);
      FLASH:       return 8'(FLASH_T - 1);
      default:     return 8'(ALLRED_T - 1);
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      MAIN_GREEN:  return MAIN_YELLOW;
      MAIN_YELLOW: return ALLRED_PRE;
      ALLRED_PRE:  return WALK;
      WALK:        return FLASH;
      FLASH:       return ALLRED_POST;
      default:     return MAIN_GREEN;
    endcase
  endfunction

  // {main_light, ped_state}; anything not named falls back to all-red / don't-walk
  function automatic logic [5:0] lamps(input state_t s);
    case (s)
      MAIN_GREEN:  return 6'b001_001;
      MAIN_YELLOW: return 6'b010_001;
      WALK:        return 6'b100_100;
      FLASH:       return 6'b100_010;
      default:     return 6'b100_001;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] pre_q, pre_d;
  logic       green_done_q, green_done_d;
  logic       request_pending_q, request_pending_d;
  logic [2:0] main_light_q, main_light_d;
  logic [2:0] ped_state_q, ped_state_d;
  logic       btn, tick, expired, go, legal, press;

`ifdef PED_BUTTON_SYNC_EN
  logic sync1_q, sync2_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {sync2_q, sync1_q} <= 2'b00;
    else {sync2_q, sync1_q} <= {sync1_q, walk_button};
  assign btn = sync2_q;
`else
  assign btn = walk_button;
`endif

  assign tick    = pre_q == 8'(CLK_PER_TICK - 1);
  assign expired = tick && timer_q == 8'd0;
  assign legal   = state_q <= ALLRED_POST;
  assign go      = state_q == MAIN_GREEN ? green_done_q && request_pending_q : expired;
  assign press   = btn && (state_q == MAIN_GREEN || state_q == MAIN_YELLOW ||
                           state_q == FLASH || state_q == ALLRED_POST);

  always_comb begin
    state_d      = state_q;
    timer_d      = tick && timer_q != 8'd0 ? timer_q - 8'd1 : timer_q;
    pre_d        = tick ? 8'd0 : pre_q + 8'd1;
    green_done_d = green_done_q || (state_q == MAIN_GREEN && expired);
    if (!legal) begin
      state_d      = ALLRED_POST;
      timer_d      = reload(ALLRED_POST);
      pre_d        = 8'd0;
      green_done_d = 1'b0;
    end else if (go) begin
      state_d      = succ(state_q);
      timer_d      = reload(succ(state_q));
      pre_d        = 8'd0;
      green_done_d = 1'b0;
    end
    request_pending_d           = state_d != WALK && (request_pending_q || press);
    {main_light_d, ped_state_d} = lamps(state_d);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q           <= ALLRED_POST;
      timer_q           <= 8'(ALLRED_T - 1);
      pre_q             <= 8'd0;
      green_done_q      <= 1'b0;
      request_pending_q <= 1'b0;
      main_light_q      <= 3'b100;
      ped_state_q       <= 3'b001;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      pre_q             <= pre_d;
      green_done_q      <= green_done_d;
      request_pending_q <= request_pending_d;
      main_light_q      <= main_light_d;
      ped_state_q       <= ped_state_d;
    end

  assign main_light      = main_light_q;
  assign ped_state       = ped_state_q;
  assign request_pending = request_pending_q;
endmodule

// File: tb/tb_ped_crossing_controller.sv
// tb_ped_crossing_controller: directed stimulus with a cycle-stamped expectation queue.
module tb_ped_crossing_controller;
  logic       clk = 1'b0, reset_n = 1'b0, walk_button = 1'b0;
  logic [2:0] ped_state, main_light;
  logic       request_pending;
  int         cyc = 0, total = 0, bad = 0;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  localparam logic [2:0] WK = 3'b100, FL = 3'b010, DW = 3'b001;

  typedef struct {
    int         c;
    logic [2:0] m;
    logic [2:0] p;
    logic       r;
  } exp_t;
  exp_t q[$];

  ped_crossing_controller dut (
    .clk(clk), .reset_n(reset_n), .walk_button(walk_button),
    .ped_state(ped_state), .main_light(main_light), .request_pending(request_pending)
  );

  always #5 clk = ~clk;

  // edge number since reset release; edge 1 is the first rising edge with reset_n=1
  always @(posedge clk or negedge reset_n) cyc <= !reset_n ? 0 : cyc + 1;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, req);
    end
  endtask

  always @(negedge clk)
    while (reset_n && q.size() > 0 && q[0].c <= cyc) begin
      if (q[0].c < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_c%0d got=none want=%b%b%b", q[0].c, q[0].m, q[0].p, q[0].r);
      end else
        chk($sformatf("c%0d", q[0].c), {main_light, ped_state, request_pending},
            {q[0].m, q[0].p, q[0].r});
      void'(q.pop_front());
    end

  task automatic ex(input int c, input logic [2:0] m, input logic [2:0] p, input logic r);
    q.push_back('{c, m, p, r});
  endtask

  task automatic goto(input int n);
    int g = 0;
    while (cyc < n && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (cyc < n) begin
      total++;
      bad++;
      $display("FAIL timeout_%0d got=%0d want=%0d", n, cyc, n);
    end
  endtask

  task automatic press(input int n);
    goto(n);
    walk_button = 1'b1;
    @(posedge clk);
    #1;
    walk_button = 1'b0;
  endtask

  task automatic drain;
    @(negedge clk);
    #1;
    chk("drained", 7'(q.size()), 7'd0);
  endtask

  task automatic release_rst;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    // idle after reset, then a single press at cycle 30
    ex(1, R, DW, 0);  ex(7, R, DW, 0);  ex(8, G, DW, 0);  ex(29, G, DW, 0);
    ex(30, G, DW, 0); ex(31, G, DW, 1); ex(32, G, DW, 1); ex(33, Y, DW, 1);
    ex(44, Y, DW, 1); ex(45, R, DW, 1); ex(52, R, DW, 1); ex(53, R, WK, 0);
    ex(72, R, WK, 0); ex(73, R, FL, 0); ex(88, R, FL, 0); ex(89, R, DW, 0);
    ex(96, R, DW, 0); ex(97, G, DW, 0); ex(130, G, DW, 0);
    release_rst();
    press(30);
    goto(130);
    drain();
    // early press, press ignored in walk, press honoured in flash
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    ex(31, G, DW, 1);  ex(33, Y, DW, 1);  ex(54, R, WK, 0);  ex(61, R, WK, 0);
    ex(70, R, WK, 0);  ex(81, R, FL, 1);  ex(89, R, DW, 1);  ex(100, G, DW, 1);
    ex(119, G, DW, 1); ex(123, Y, DW, 1); ex(146, R, WK, 0);
    release_rst();
    press(10);
    press(60);
    press(80);
    goto(146);
    drain();
    // asynchronous reset in the middle of walk
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_rst", {main_light, ped_state, request_pending}, {R, DW, 1'b0});
    repeat (3) @(posedge clk);
    ex(1, R, DW, 0); ex(7, R, DW, 0); ex(8, G, DW, 0); ex(20, G, DW, 0);
    release_rst();
    goto(20);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
